// File: rtl/dds_cmd_pkg.sv
// Shared constants and types for the DDS command sequencer.
//   HDR_BYTE    frame start marker
//   FRAME_LEN   bytes following the header (CMD, D3..D0, CSUM)
//   DATA_BYTES  payload bytes inside a frame
//   OP_*        opcode values carried in CMD[7:4]
//   state_t     frame parser states
package dds_cmd_pkg;

   localparam logic [7:0] HDR_BYTE   = 8'hAA;
   localparam int         FRAME_LEN  = 6;
   localparam int         DATA_BYTES = FRAME_LEN - 2;

   localparam logic [3:0] OP_NOP      = 4'h0;
   localparam logic [3:0] OP_WR_FREQ  = 4'h1;
   localparam logic [3:0] OP_WR_PHASE = 4'h2;
   localparam logic [3:0] OP_COMMIT   = 4'h3;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_CMD  = 3'd1,
      ST_DATA = 3'd2,
      ST_CSUM = 3'd3,
      ST_EXEC = 3'd4
   } state_t;

   function automatic logic op_legal(input logic [3:0] op);
      return op inside {OP_NOP, OP_WR_FREQ, OP_WR_PHASE, OP_COMMIT};
   endfunction

endpackage

// File: rtl/dds_cmd_sequencer_if.sv
// Bus between the UART receiver / DDS cores and the command sequencer.
//   RX_Done_Sig, RX_Data   byte strobe and byte from the UART receiver
//   RX_En_Sig              receiver enable
//   fword_1..4, phase_1..4 active tuning words / phase offsets to the DDS cores
//   Update_Sig, Cmd_Ok, Cmd_Err  single-cycle status pulses
// master: the sequencer side (drives the DDS outputs); slave: the environment.
interface dds_cmd_sequencer_if #(
   parameter int FW_W = 32,
   parameter int PH_W = 10
);
   logic            RX_Done_Sig;
   logic [7:0]      RX_Data;
   logic            RX_En_Sig;
   logic [FW_W-1:0] fword_1, fword_2, fword_3, fword_4;
   logic [PH_W-1:0] phase_1, phase_2, phase_3, phase_4;
   logic            Update_Sig;
   logic            Cmd_Ok;
   logic            Cmd_Err;

   modport master (
      input  RX_Done_Sig, RX_Data,
      output RX_En_Sig, fword_1, fword_2, fword_3, fword_4,
             phase_1, phase_2, phase_3, phase_4, Update_Sig, Cmd_Ok, Cmd_Err
   );

   modport slave (
      output RX_Done_Sig, RX_Data,
      input  RX_En_Sig, fword_1, fword_2, fword_3, fword_4,
             phase_1, phase_2, phase_3, phase_4, Update_Sig, Cmd_Ok, Cmd_Err
   );
endinterface

// File: rtl/dds_cmd_timer.sv
// Inter-byte timeout counter.
//   CLK, RSTn  clock, async active-low reset
//   clr        a byte arrived: restart from 0 (wins over expiry)
//   run        parser is inside a frame; when low the counter is held at 0
//   expire     combinational pulse: the idle count has reached TIMEOUT_CYC
module dds_cmd_timer #(
   parameter int TIMEOUT_CYC = 500000
) (
   input  logic CLK,
   input  logic RSTn,
   input  logic clr,
   input  logic run,
   output logic expire
);
   localparam int              CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn)                cnt_q <= '0;
      else if (clr || !run)     cnt_q <= '0;
      else if (cnt_q != LIMIT)  cnt_q <= cnt_q + CNT_W'(1);
   end

   assign expire = run && !clr && (cnt_q == LIMIT);
endmodule

// File: rtl/dds_cmd_sequencer.sv
// Framed configuration packet parser programming four DDS channels.
// Frame: AA | CMD{op,rsv,ch} | D3 D2 D1 D0 | CSUM (XOR of CMD..D0).
// Writes land in shadow banks; COMMIT copies every shadow to the active
// outputs in one cycle so all channels retune together.
//   CLK, RSTn  clock, async active-low reset
//   bus        dds_cmd_sequencer_if master modport (UART byte in, DDS words out)
import dds_cmd_pkg::*;

module dds_cmd_sequencer #(
   parameter int FW_W        = 32,
   parameter int PH_W        = 10,
   parameter int TIMEOUT_CYC = 500000
) (
   input  logic                  CLK,
   input  logic                  RSTn,
   dds_cmd_sequencer_if.master   bus
);
   state_t state_q, state_d;

   logic            rx_done;
   logic [7:0]      rx_byte;
   logic [1:0]      bcnt_q;
   logic [3:0]      op_q;
   logic [1:0]      ch_q;
   logic [31:0]     data_q;
   logic [7:0]      csum_q;
   logic            match_q;
   logic            rx_en_q, upd_q, ok_q, err_q;
   logic            tmr_run, tmr_exp, exec_ok;

   logic [3:0][FW_W-1:0] shd_f, act_f;
   logic [3:0][PH_W-1:0] shd_p, act_p;

   assign rx_done = bus.RX_Done_Sig;
   assign rx_byte = bus.RX_Data;
   assign tmr_run = state_q inside {ST_CMD, ST_DATA, ST_CSUM};
   assign exec_ok = match_q && op_legal(op_q);

   dds_cmd_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
      .CLK    (CLK),
      .RSTn   (RSTn),
      .clr    (rx_done),
      .run    (tmr_run),
      .expire (tmr_exp)
   );

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // tmr_exp already excludes cycles with a byte, so a byte always wins.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (rx_done && rx_byte == HDR_BYTE) state_d = ST_CMD;
         ST_CMD:  begin
            if (rx_done)      state_d = ST_DATA;
            else if (tmr_exp) state_d = ST_IDLE;
         end
         ST_DATA: begin
            if (rx_done) begin
               if (bcnt_q == 2'(DATA_BYTES - 1)) state_d = ST_CSUM;
            end else if (tmr_exp) state_d = ST_IDLE;
         end
         ST_CSUM: begin
            if (rx_done)      state_d = ST_EXEC;
            else if (tmr_exp) state_d = ST_IDLE;
         end
         ST_EXEC: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Frame capture: opcode/channel, payload shift register, running XOR.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         op_q    <= '0;
         ch_q    <= '0;
         bcnt_q  <= '0;
         data_q  <= '0;
         csum_q  <= '0;
         match_q <= 1'b0;
      end else if (rx_done) begin
         case (state_q)
            ST_CMD: begin
               op_q   <= rx_byte[7:4];
               ch_q   <= rx_byte[1:0];
               csum_q <= rx_byte;
               bcnt_q <= '0;
            end
            ST_DATA: begin
               data_q <= {data_q[23:0], rx_byte};
               csum_q <= csum_q ^ rx_byte;
               bcnt_q <= bcnt_q + 2'd1;
            end
            ST_CSUM: match_q <= (rx_byte == csum_q);
            default: ;
         endcase
      end
   end

   // Execution: shadow/active banks and status pulses, all visible the
   // cycle after EXEC.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         shd_f   <= '0;
         shd_p   <= '0;
         act_f   <= '0;
         act_p   <= '0;
         rx_en_q <= 1'b0;
         upd_q   <= 1'b0;
         ok_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         rx_en_q <= 1'b1;
         upd_q   <= 1'b0;
         ok_q    <= 1'b0;
         err_q   <= tmr_exp;
         if (state_q == ST_EXEC) begin
            if (exec_ok) begin
               ok_q <= 1'b1;
               case (op_q)
                  OP_WR_FREQ:  shd_f[ch_q] <= data_q[FW_W-1:0];
                  OP_WR_PHASE: shd_p[ch_q] <= data_q[PH_W-1:0];
                  OP_COMMIT: begin
                     act_f <= shd_f;
                     act_p <= shd_p;
                     upd_q <= 1'b1;
                  end
                  default: ;
               endcase
            end else begin
               err_q <= 1'b1;
            end
         end
      end
   end

   assign bus.RX_En_Sig  = rx_en_q;
   assign bus.Update_Sig = upd_q;
   assign bus.Cmd_Ok     = ok_q;
   assign bus.Cmd_Err    = err_q;
   assign bus.fword_1    = act_f[0];
   assign bus.fword_2    = act_f[1];
   assign bus.fword_3    = act_f[2];
   assign bus.fword_4    = act_f[3];
   assign bus.phase_1    = act_p[0];
   assign bus.phase_2    = act_p[1];
   assign bus.phase_3    = act_p[2];
   assign bus.phase_4    = act_p[3];
endmodule

// File: tb/tb_dds_cmd_sequencer.sv
// Bench for dds_cmd_sequencer: directed frame table, multi-cycle corner
// sequences (timeout, slow bytes, reset mid-frame) and random frames checked
// against a channel-level model of shadow and active banks.
module tb_dds_cmd_sequencer;
   localparam int FW_W = 32;
   localparam int PH_W = 10;
   localparam int TMO  = 40;

   logic CLK = 1'b0;
   logic RSTn = 1'b0;
   always #5 CLK = ~CLK;

   dds_cmd_sequencer_if #(.FW_W(FW_W), .PH_W(PH_W)) bus ();
   dds_cmd_sequencer #(.FW_W(FW_W), .PH_W(PH_W), .TIMEOUT_CYC(TMO)) dut (
      .CLK  (CLK),
      .RSTn (RSTn),
      .bus  (bus)
   );

   int total = 0;
   int bad   = 0;
   int ok_cnt = 0;
   int err_cnt = 0;

   logic [31:0]     mf [4];
   logic [31:0]     af [4];
   logic [PH_W-1:0] mp [4];
   logic [PH_W-1:0] ap [4];

   typedef struct {
      logic [7:0]  cmd;
      logic [31:0] d;
      logic [7:0]  cs;
      logic        ok, err, upd;
      int          probe;      // 0 none, 1 fword_3, 2 phase_2, 3 fword_2
      logic [31:0] probe_exp;
   } vec_t;

   vec_t tv [13];

   always @(negedge CLK) begin
      if (RSTn) begin
         if (bus.Cmd_Ok)  ok_cnt++;
         if (bus.Cmd_Err) err_cnt++;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         mf[i] = '0; af[i] = '0; mp[i] = '0; ap[i] = '0;
      end
   endtask

   function automatic logic [31:0] out_f(input int i);
      case (i)
         0: return bus.fword_1;
         1: return bus.fword_2;
         2: return bus.fword_3;
         default: return bus.fword_4;
      endcase
   endfunction

   function automatic logic [PH_W-1:0] out_p(input int i);
      case (i)
         0: return bus.phase_1;
         1: return bus.phase_2;
         2: return bus.phase_3;
         default: return bus.phase_4;
      endcase
   endfunction

   task automatic check_outputs(input string tag);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("%s fword_%0d", tag, i + 1), out_f(i), af[i]);
         chk($sformatf("%s phase_%0d", tag, i + 1), 32'(out_p(i)), 32'(ap[i]));
      end
   endtask

   function automatic logic [7:0] mk_cs(input logic [7:0] cmd, input logic [31:0] d);
      return cmd ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
   endfunction

   function automatic logic frame_ok(input logic [7:0] cmd, input logic [31:0] d, input logic [7:0] cs);
      return (cs == mk_cs(cmd, d)) && (cmd[7:4] <= 4'h3);
   endfunction

   task automatic model_apply(input logic [7:0] cmd, input logic [31:0] d);
      int ch;
      ch = int'(cmd[1:0]);
      case (cmd[7:4])
         4'h1: mf[ch] = d;
         4'h2: mp[ch] = d[PH_W-1:0];
         4'h3: for (int i = 0; i < 4; i++) begin af[i] = mf[i]; ap[i] = mp[i]; end
         default: ;
      endcase
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      bus.RX_Data     = b;
      bus.RX_Done_Sig = 1'b1;
      tick();
      bus.RX_Done_Sig = 1'b0;
      repeat (gap) tick();
   endtask

   // Sends a full frame and checks the pulse timing around the last byte.
   task automatic send_frame(input string tag, input logic [7:0] cmd, input logic [31:0] d,
                             input logic [7:0] cs, input int gap,
                             input logic e_ok, input logic e_err, input logic e_upd);
      send_byte(8'hAA, gap);
      send_byte(cmd, gap);
      for (int k = 3; k >= 0; k--) send_byte(d[8*k +: 8], gap);
      send_byte(cs, 0);
      chk({tag, " ok@n+1"},  32'(bus.Cmd_Ok), 0);
      chk({tag, " err@n+1"}, 32'(bus.Cmd_Err), 0);
      tick();
      chk({tag, " ok@n+2"},  32'(bus.Cmd_Ok), 32'(e_ok));
      chk({tag, " err@n+2"}, 32'(bus.Cmd_Err), 32'(e_err));
      chk({tag, " upd@n+2"}, 32'(bus.Update_Sig), 32'(e_upd));
      if (frame_ok(cmd, d, cs)) model_apply(cmd, d);
      check_outputs(tag);
      tick();
      chk({tag, " ok@n+3"},  32'(bus.Cmd_Ok), 0);
      chk({tag, " err@n+3"}, 32'(bus.Cmd_Err), 0);
      chk({tag, " upd@n+3"}, 32'(bus.Update_Sig), 0);
   endtask

   initial begin
      int found, elapsed, ok0, err0;
      logic [7:0]  rc, rcs, junk;
      logic [31:0] rd;
      logic        rok;

      tv[0]  = '{8'h12, 32'h0000_0100, 8'h13, 1, 0, 0, 1, 32'h0};
      tv[1]  = '{8'h30, 32'h0,         8'h30, 1, 0, 1, 1, 32'h100};
      tv[2]  = '{8'h21, 32'h0000_03FF, 8'hDD, 1, 0, 0, 2, 32'h0};
      tv[3]  = '{8'h30, 32'h0,         8'h30, 1, 0, 1, 2, 32'h3FF};
      tv[4]  = '{8'h12, 32'h0000_0100, 8'h14, 0, 1, 0, 1, 32'h100};
      tv[5]  = '{8'h50, 32'h0,         8'h50, 0, 1, 0, 0, 32'h0};
      tv[6]  = '{8'h00, 32'h0,         8'h00, 1, 0, 0, 1, 32'h100};
      tv[7]  = '{8'h11, 32'hAAAA_AAAA, 8'h11, 1, 0, 0, 3, 32'h0};
      tv[8]  = '{8'h13, 32'hDEAD_BEEF, 8'h31, 1, 0, 0, 0, 32'h0};
      tv[9]  = '{8'h33, 32'h0,         8'h33, 1, 0, 1, 3, 32'hAAAA_AAAA};
      tv[10] = '{8'h12, 32'h0000_0055, 8'h47, 1, 0, 0, 1, 32'h100};
      tv[11] = '{8'h30, 32'h0,         8'h31, 0, 1, 0, 1, 32'h100};
      tv[12] = '{8'hF0, 32'h0,         8'hF0, 0, 1, 0, 0, 32'h0};

      bus.RX_Done_Sig = 1'b0;
      bus.RX_Data     = 8'h00;
      model_reset();

      // Reset state
      repeat (5) tick();
      check_outputs("reset");
      chk("reset rx_en", 32'(bus.RX_En_Sig), 0);
      chk("reset ok",    32'(bus.Cmd_Ok), 0);
      chk("reset err",   32'(bus.Cmd_Err), 0);
      chk("reset upd",   32'(bus.Update_Sig), 0);
      RSTn = 1'b1;
      chk("rx_en before edge", 32'(bus.RX_En_Sig), 0);
      tick();
      chk("rx_en after release", 32'(bus.RX_En_Sig), 1);
      tick();

      // Directed frame table
      for (int i = 0; i < 13; i++) begin
         if (i == 6) send_byte(8'h55, 2);
         send_frame($sformatf("tv%0d", i), tv[i].cmd, tv[i].d, tv[i].cs, 1,
                    tv[i].ok, tv[i].err, tv[i].upd);
         case (tv[i].probe)
            1: chk($sformatf("tv%0d probe fword_3", i), bus.fword_3, tv[i].probe_exp);
            2: chk($sformatf("tv%0d probe phase_2", i), 32'(bus.phase_2), tv[i].probe_exp);
            3: chk($sformatf("tv%0d probe fword_2", i), bus.fword_2, tv[i].probe_exp);
            default: ;
         endcase
         repeat (2) tick();
      end

      // Timeout mid-frame
      err0 = err_cnt;
      ok0  = ok_cnt;
      send_byte(8'hAA, 1);
      send_byte(8'h12, 1);
      send_byte(8'h00, 0);
      found = 0;
      elapsed = 0;
      for (int i = 1; i <= TMO + 10 && found == 0; i++) begin
         tick();
         if (bus.Cmd_Err) begin found = 1; elapsed = i; end
      end
      chk("timeout err seen", 32'(found), 1);
      chk("timeout latency in window", 32'(elapsed >= TMO - 1 && elapsed <= TMO + 2), 1);
      tick();
      chk("timeout err one cycle", 32'(bus.Cmd_Err), 0);
      chk("timeout err count", 32'(err_cnt - err0), 1);
      chk("timeout no ok", 32'(ok_cnt - ok0), 0);
      send_frame("after_tmo_wr", 8'h10, 32'h1234_5678, 8'h18, 1, 1, 0, 0);
      send_frame("after_tmo_cm", 8'h30, 32'h0, 8'h30, 1, 1, 0, 1);
      chk("after_tmo fword_1", bus.fword_1, 32'h1234_5678);

      // Slow bytes just under the timeout are still one frame
      send_frame("slow_wr", 8'h22, 32'h0000_0155, 8'h76, TMO - 2, 1, 0, 0);
      send_frame("slow_cm", 8'h30, 32'h0, 8'h30, 1, 1, 0, 1);

      // Reset mid-frame, then the frame tail alone must be ignored
      send_byte(8'hAA, 1);
      send_byte(8'h12, 1);
      send_byte(8'h00, 1);
      RSTn = 1'b0;
      #1;
      model_reset();
      check_outputs("midrst");
      chk("midrst rx_en", 32'(bus.RX_En_Sig), 0);
      repeat (3) tick();
      RSTn = 1'b1;
      tick();
      chk("midrst rx_en back", 32'(bus.RX_En_Sig), 1);
      ok0  = ok_cnt;
      err0 = err_cnt;
      send_byte(8'h00, 1);
      send_byte(8'h01, 1);
      send_byte(8'h00, 1);
      send_byte(8'h13, 4);
      chk("midrst tail no ok",  32'(ok_cnt - ok0), 0);
      chk("midrst tail no err", 32'(err_cnt - err0), 0);
      send_frame("midrst_wr", 8'h12, 32'h0000_0100, 8'h13, 1, 1, 0, 0);
      send_frame("midrst_cm", 8'h30, 32'h0, 8'h30, 1, 1, 0, 1);

      // Random frames against the model
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            junk = 8'($urandom_range(0, 255));
            if (junk == 8'hAA) junk = 8'h55;
            send_byte(junk, 1);
         end
         rc  = {4'($urandom_range(0, 5)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
         rd  = $urandom;
         rcs = mk_cs(rc, rd);
         if ($urandom_range(0, 9) == 0) rcs = rcs ^ 8'($urandom_range(1, 255));
         rok = frame_ok(rc, rd, rcs);
         send_frame($sformatf("rnd%0d", n), rc, rd, rcs, int'($urandom_range(0, 3)),
                    rok, !rok, rok && rc[7:4] == 4'h3);
         repeat ($urandom_range(0, 2)) tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
